// File: rtl/mem_boot_ctrl.sv
// Boot sequencer and arbiter for the shared data-memory port: streams an image in,
// holds the CPU in reset, hands the port to the CPU, then reads the memory back out.
module mem_boot_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int LOAD_BASE   = 8,
  parameter int DUMP_BASE   = 8,
  parameter int DUMP_LIMIT  = 2048,
  parameter int COOL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic              halt_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_m_addr,
  input  logic [DATA_W-1:0] cpu_m_wr_data,
  input  logic              cpu_m_rd,
  input  logic              cpu_m_wr,
  input  logic              cpu_m_en,
  output logic [DATA_W-1:0] cpu_m_rd_data,
  output logic              cpu_reset_,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_en,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              load_ovf,
  output logic [2:0]        dbg_state
);

  // Loader handshake: a byte transfers on any cycle where ld_valid && ld_ready;
  // ld_ready is high for every LOAD cycle and never depends on ld_valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COOL  = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int CNT_W = $clog2(COOL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LOAD_INIT = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] DUMP_INIT = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(DUMP_LIMIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
  localparam logic [CNT_W-1:0]  COOL_INIT = CNT_W'(COOL_CYCLES - 1);

  state_t              state;
  logic [ADDR_W-1:0]   load_ptr;
  logic [ADDR_W-1:0]   dump_ptr;
  logic [CNT_W-1:0]    cool_cnt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= S_IDLE;
      load_ptr   <= LOAD_INIT;
      dump_ptr   <= DUMP_INIT;
      cool_cnt   <= COOL_INIT;
      cpu_reset_ <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      load_ovf   <= 1'b0;
    end else begin
      // Each read issued in DUMP comes back as a beat on the following cycle.
      dump_valid <= (state == S_DUMP);
      dump_addr  <= dump_ptr;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            load_ptr <= LOAD_INIT;
            dump_ptr <= DUMP_INIT;
            cool_cnt <= COOL_INIT;
            load_ovf <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            load_ptr <= load_ptr + 1'b1;
            if (ld_last) begin
              state <= S_COOL;
            end else if (load_ptr == ADDR_TOP) begin
              load_ovf <= 1'b1;
              state    <= S_COOL;
            end
          end
        end
        S_COOL: begin
          if (cool_cnt == '0) begin
            state      <= S_RUN;
            cpu_reset_ <= 1'b1;
          end else begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (halt_req) begin
            state      <= S_DUMP;
            cpu_reset_ <= 1'b0;
          end
        end
        S_DUMP: begin
          dump_ptr <= dump_ptr + 1'b1;
          if (dump_ptr == DUMP_LAST) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_en      = 1'b0;
    case (state)
      S_LOAD: begin
        mem_addr    = load_ptr;
        mem_wr_data = ld_data;
        mem_wr      = ld_valid;
        mem_en      = ld_valid;
      end
      S_RUN: begin
        mem_addr    = cpu_m_addr;
        mem_wr_data = cpu_m_wr_data;
        mem_rd      = cpu_m_rd;
        mem_wr      = cpu_m_wr;
        mem_en      = cpu_m_en;
      end
      S_DUMP: begin
        mem_addr = dump_ptr;
        mem_rd   = 1'b1;
        mem_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ld_ready      = (state == S_LOAD);
  assign done          = (state == S_DONE);
  assign cpu_m_rd_data = mem_rd_data;
  assign dump_data     = mem_rd_data;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Directed bench for mem_boot_ctrl: load, cool-down, CPU pass-through, full dump,
// restart from DONE, reset mid-dump, and load overflow at the top of memory.
module tb_mem_boot_ctrl;

  logic        clk;
  logic        reset_;
  logic        start, halt_req, ld_valid, ld_last, ld_ready;
  logic [7:0]  ld_data;
  logic [11:0] cpu_m_addr;
  logic [7:0]  cpu_m_wr_data, cpu_m_rd_data;
  logic        cpu_m_rd, cpu_m_wr, cpu_m_en, cpu_reset_;
  logic [11:0] mem_addr, dump_addr;
  logic [7:0]  mem_wr_data, mem_rd_data, dump_data;
  logic        mem_rd, mem_wr, mem_en, dump_valid, done, load_ovf;
  logic [2:0]  dbg_state;

  // Second instance with the load base two bytes below the top of memory.
  logic        o_start, o_ld_valid, o_ld_last, o_ld_ready;
  logic [7:0]  o_ld_data, o_cpu_m_rd_data, o_mem_wr_data, o_dump_data;
  logic        o_cpu_reset_, o_mem_rd, o_mem_wr, o_mem_en, o_dump_valid, o_done, o_load_ovf;
  logic [11:0] o_mem_addr, o_dump_addr;
  logic [2:0]  o_dbg_state;

  int cnt_total = 0;
  int cnt_bad   = 0;

  mem_boot_ctrl u_dut (
    .clk(clk), .reset_(reset_), .start(start), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_m_addr(cpu_m_addr), .cpu_m_wr_data(cpu_m_wr_data), .cpu_m_rd(cpu_m_rd),
    .cpu_m_wr(cpu_m_wr), .cpu_m_en(cpu_m_en), .cpu_m_rd_data(cpu_m_rd_data),
    .cpu_reset_(cpu_reset_), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_en(mem_en),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done), .load_ovf(load_ovf), .dbg_state(dbg_state)
  );

  mem_boot_ctrl #(.LOAD_BASE(4094)) u_ovf (
    .clk(clk), .reset_(reset_), .start(o_start), .halt_req(1'b0),
    .ld_valid(o_ld_valid), .ld_data(o_ld_data), .ld_last(o_ld_last), .ld_ready(o_ld_ready),
    .cpu_m_addr(12'h000), .cpu_m_wr_data(8'h00), .cpu_m_rd(1'b0),
    .cpu_m_wr(1'b0), .cpu_m_en(1'b0), .cpu_m_rd_data(o_cpu_m_rd_data),
    .cpu_reset_(o_cpu_reset_), .mem_addr(o_mem_addr), .mem_wr_data(o_mem_wr_data),
    .mem_rd_data(8'h00), .mem_rd(o_mem_rd), .mem_wr(o_mem_wr), .mem_en(o_mem_en),
    .dump_valid(o_dump_valid), .dump_addr(o_dump_addr), .dump_data(o_dump_data),
    .done(o_done), .load_ovf(o_load_ovf), .dbg_state(o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Data memory stand-in: synchronous write, one-cycle registered read.
  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  logic [7:0] mem [0:4095];
  logic       mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_wr) mem[mem_addr] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= mem[mem_addr];
    end
  end

  // Expected memory contents after the first load and CPU write.
  function automatic logic [7:0] exp_byte(input int a);
    case (a)
      8:       return 8'hAA;
      9:       return 8'hBB;
      10:      return 8'hCC;
      16:      return 8'h5A;
      default: return pat(a);
    endcase
  endfunction

  // Driver tasks with inline checks
  task automatic test_reset;
    reset_ = 1'b0; start = 0; halt_req = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    cpu_m_addr = 0; cpu_m_wr_data = 0; cpu_m_rd = 0; cpu_m_wr = 0; cpu_m_en = 0;
    o_start = 0; o_ld_valid = 0; o_ld_data = 0; o_ld_last = 0;
    repeat (3) @(negedge clk);
    #1;
    cnt_total++; if (dbg_state !== 3'd0) begin cnt_bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    cnt_total++; if (cpu_reset_ !== 1'b0) begin cnt_bad++; $display("FAIL reset_cpu_reset got=%b exp=0", cpu_reset_); end
    cnt_total++; if (ld_ready !== 1'b0) begin cnt_bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    cnt_total++; if ({mem_en, mem_rd, mem_wr} !== 3'b000) begin cnt_bad++; $display("FAIL reset_strobes got=%b exp=000", {mem_en, mem_rd, mem_wr}); end
    cnt_total++; if (dump_valid !== 1'b0) begin cnt_bad++; $display("FAIL reset_dump_valid got=%b exp=0", dump_valid); end
    cnt_total++; if (done !== 1'b0) begin cnt_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    cnt_total++; if (load_ovf !== 1'b0) begin cnt_bad++; $display("FAIL reset_load_ovf got=%b exp=0", load_ovf); end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_ignored_idle;
    @(negedge clk);
    halt_req = 1; ld_valid = 1; ld_data = 8'h55;
    #1;
    cnt_total++; if (mem_en !== 1'b0) begin cnt_bad++; $display("FAIL idle_ignore_mem_en got=%b exp=0", mem_en); end
    @(negedge clk);
    halt_req = 0; ld_valid = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd0) begin cnt_bad++; $display("FAIL idle_ignore_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_load;
    logic [7:0] bytes [3];
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd1) begin cnt_bad++; $display("FAIL load_state got=%0d exp=1", dbg_state); end
    cnt_total++; if (ld_ready !== 1'b1) begin cnt_bad++; $display("FAIL load_ld_ready got=%b exp=1", ld_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_valid = 1; ld_data = bytes[i]; ld_last = (i == 2);
      #1;
      cnt_total++; if ({mem_en, mem_wr, mem_rd} !== 3'b110) begin cnt_bad++; $display("FAIL load_strobes_%0d got=%b exp=110", i, {mem_en, mem_wr, mem_rd}); end
      cnt_total++; if (mem_addr !== 12'(8 + i)) begin cnt_bad++; $display("FAIL load_addr_%0d got=%0d exp=%0d", i, mem_addr, 8 + i); end
      cnt_total++; if (mem_wr_data !== bytes[i]) begin cnt_bad++; $display("FAIL load_data_%0d got=%h exp=%h", i, mem_wr_data, bytes[i]); end
    end
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd2) begin cnt_bad++; $display("FAIL load_to_cool got=%0d exp=2", dbg_state); end
    cnt_total++; if (ld_ready !== 1'b0) begin cnt_bad++; $display("FAIL cool_ld_ready got=%b exp=0", ld_ready); end
    cnt_total++; if (cpu_reset_ !== 1'b0) begin cnt_bad++; $display("FAIL cool_cpu_reset got=%b exp=0", cpu_reset_); end
  endtask

  // Entered one half-cycle after the ld_last acceptance edge.
  task automatic test_cool;
    int rise_k = 0;
    int port_busy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cpu_reset_ === 1'b1) begin
        rise_k = k;
        break;
      end
      if (mem_en !== 1'b0) port_busy++;
    end
    cnt_total++; if (rise_k != 32) begin cnt_bad++; $display("FAIL cool_length got=%0d exp=32", rise_k); end
    cnt_total++; if (port_busy != 0) begin cnt_bad++; $display("FAIL cool_port_idle got=%0d exp=0", port_busy); end
    cnt_total++; if (dbg_state !== 3'd3) begin cnt_bad++; $display("FAIL cool_to_run got=%0d exp=3", dbg_state); end
  endtask

  task automatic test_run;
    cpu_m_en = 1; cpu_m_wr = 1; cpu_m_addr = 12'h010; cpu_m_wr_data = 8'h5A;
    #1;
    cnt_total++; if ({mem_en, mem_wr, mem_rd} !== 3'b110) begin cnt_bad++; $display("FAIL run_wr_strobes got=%b exp=110", {mem_en, mem_wr, mem_rd}); end
    cnt_total++; if (mem_addr !== 12'h010) begin cnt_bad++; $display("FAIL run_wr_addr got=%h exp=010", mem_addr); end
    cnt_total++; if (mem_wr_data !== 8'h5A) begin cnt_bad++; $display("FAIL run_wr_data got=%h exp=5a", mem_wr_data); end
    @(negedge clk);
    cpu_m_wr = 0; cpu_m_rd = 1;
    #1;
    cnt_total++; if ({mem_en, mem_wr, mem_rd} !== 3'b101) begin cnt_bad++; $display("FAIL run_rd_strobes got=%b exp=101", {mem_en, mem_wr, mem_rd}); end
    @(negedge clk);
    cpu_m_en = 0; cpu_m_rd = 0; start = 1;
    #1;
    cnt_total++; if (cpu_m_rd_data !== 8'h5A) begin cnt_bad++; $display("FAIL run_rd_data got=%h exp=5a", cpu_m_rd_data); end
    @(negedge clk);
    start = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd3) begin cnt_bad++; $display("FAIL run_start_ignored got=%0d exp=3", dbg_state); end
  endtask

  task automatic test_dump;
    int beats = 0;
    int exp_addr = 8;
    @(negedge clk);
    halt_req = 1; cpu_m_en = 1; cpu_m_rd = 1; cpu_m_addr = 12'h008;
    #1;
    cnt_total++; if ({mem_en, mem_rd, mem_addr} !== {2'b11, 12'h008}) begin cnt_bad++; $display("FAIL halt_cycle_pass got=%b%b/%h exp=11/008", mem_en, mem_rd, mem_addr); end
    @(negedge clk);
    halt_req = 0; cpu_m_rd = 0; cpu_m_wr = 1; cpu_m_addr = 12'h020; cpu_m_wr_data = 8'hEE;
    #1;
    cnt_total++; if (cpu_reset_ !== 1'b0) begin cnt_bad++; $display("FAIL halt_cpu_reset got=%b exp=0", cpu_reset_); end
    cnt_total++; if (dbg_state !== 3'd4) begin cnt_bad++; $display("FAIL halt_to_dump got=%0d exp=4", dbg_state); end
    cnt_total++; if ({mem_en, mem_wr, mem_rd} !== 3'b101) begin cnt_bad++; $display("FAIL dump_strobes got=%b exp=101", {mem_en, mem_wr, mem_rd}); end
    cnt_total++; if (mem_addr !== 12'h008) begin cnt_bad++; $display("FAIL dump_first_addr got=%h exp=008", mem_addr); end
    cnt_total++; if (dump_valid !== 1'b0) begin cnt_bad++; $display("FAIL dump_no_early_beat got=%b exp=0", dump_valid); end
    for (int k = 0; k < 2200; k++) begin
      if (done === 1'b1) break;
      if (dump_valid === 1'b1) begin
        cnt_total++;
        if (dump_addr !== 12'(exp_addr) || dump_data !== exp_byte(exp_addr)) begin
          cnt_bad++;
          $display("FAIL dump_beat_%0d got=%h:%h exp=%h:%h", beats, dump_addr, dump_data, 12'(exp_addr), exp_byte(exp_addr));
        end
        exp_addr++;
        beats++;
      end
      @(negedge clk);
      #1;
    end
    cpu_m_en = 0; cpu_m_wr = 0;
    #1;
    cnt_total++; if (beats != 2040) begin cnt_bad++; $display("FAIL dump_beat_count got=%0d exp=2040", beats); end
    cnt_total++; if (done !== 1'b1) begin cnt_bad++; $display("FAIL dump_done got=%b exp=1", done); end
    cnt_total++; if (dump_valid !== 1'b0) begin cnt_bad++; $display("FAIL done_dump_valid got=%b exp=0", dump_valid); end
    cnt_total++; if ({cpu_reset_, mem_en} !== 2'b00) begin cnt_bad++; $display("FAIL done_idle got=%b exp=00", {cpu_reset_, mem_en}); end
  endtask

  task automatic test_start_in_done;
    @(negedge clk);
    start = 1; ld_valid = 1; ld_data = 8'h77; ld_last = 1;
    #1;
    cnt_total++; if ({ld_ready, mem_en} !== 2'b00) begin cnt_bad++; $display("FAIL done_start_byte_refused got=%b exp=00", {ld_ready, mem_en}); end
    @(negedge clk);
    start = 0; ld_valid = 0; ld_last = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd1) begin cnt_bad++; $display("FAIL restart_state got=%0d exp=1", dbg_state); end
    cnt_total++; if (done !== 1'b0) begin cnt_bad++; $display("FAIL restart_done_clear got=%b exp=0", done); end
    cnt_total++; if (mem_addr !== 12'h008) begin cnt_bad++; $display("FAIL restart_load_ptr got=%h exp=008", mem_addr); end
  endtask

  task automatic test_reset_mid_dump;
    int waited = 0;
    ld_valid = 1; ld_data = 8'h11; ld_last = 1;
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
    while (dbg_state !== 3'd3 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    cnt_total++; if (dbg_state !== 3'd3) begin cnt_bad++; $display("FAIL rerun_reach_run got=%0d exp=3", dbg_state); end
    halt_req = 1;
    @(negedge clk);
    halt_req = 0;
    repeat (100) @(negedge clk);
    #1;
    cnt_total++; if (dump_valid !== 1'b1) begin cnt_bad++; $display("FAIL mid_dump_active got=%b exp=1", dump_valid); end
    reset_ = 1'b0;
    #1;
    cnt_total++; if (dbg_state !== 3'd0) begin cnt_bad++; $display("FAIL async_reset_state got=%0d exp=0", dbg_state); end
    cnt_total++; if ({dump_valid, cpu_reset_, mem_en, mem_rd, done, ld_ready} !== 6'b0) begin cnt_bad++; $display("FAIL async_reset_outputs got=%b exp=000000", {dump_valid, cpu_reset_, mem_en, mem_rd, done, ld_ready}); end
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0; ld_valid = 1; ld_data = 8'h22; ld_last = 1;
    #1;
    cnt_total++; if ({mem_en, mem_wr, mem_addr} !== {2'b11, 12'h008}) begin cnt_bad++; $display("FAIL reset_restart_write got=%b%b/%h exp=11/008", mem_en, mem_wr, mem_addr); end
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
    #1;
    cnt_total++; if (dbg_state !== 3'd2) begin cnt_bad++; $display("FAIL reset_restart_cool got=%0d exp=2", dbg_state); end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    o_start = 1;
    @(negedge clk);
    o_start = 0; o_ld_valid = 1; o_ld_data = 8'hA1; o_ld_last = 0;
    #1;
    cnt_total++; if ({o_mem_en, o_mem_wr, o_mem_addr} !== {2'b11, 12'hFFE}) begin cnt_bad++; $display("FAIL ovf_write0 got=%b%b/%h exp=11/ffe", o_mem_en, o_mem_wr, o_mem_addr); end
    @(negedge clk);
    o_ld_data = 8'hA2;
    #1;
    cnt_total++; if ({o_mem_en, o_mem_wr, o_mem_addr} !== {2'b11, 12'hFFF}) begin cnt_bad++; $display("FAIL ovf_write1 got=%b%b/%h exp=11/fff", o_mem_en, o_mem_wr, o_mem_addr); end
    cnt_total++; if (o_load_ovf !== 1'b0) begin cnt_bad++; $display("FAIL ovf_early got=%b exp=0", o_load_ovf); end
    @(negedge clk);
    o_ld_data = 8'hA3;
    #1;
    cnt_total++; if ({o_ld_ready, o_mem_en} !== 2'b00) begin cnt_bad++; $display("FAIL ovf_third_refused got=%b exp=00", {o_ld_ready, o_mem_en}); end
    cnt_total++; if (o_load_ovf !== 1'b1) begin cnt_bad++; $display("FAIL ovf_flag got=%b exp=1", o_load_ovf); end
    cnt_total++; if (o_dbg_state !== 3'd2) begin cnt_bad++; $display("FAIL ovf_to_cool got=%0d exp=2", o_dbg_state); end
    @(negedge clk);
    o_ld_valid = 0;
    cnt_total++; if (load_ovf !== 1'b0) begin cnt_bad++; $display("FAIL main_no_ovf got=%b exp=0", load_ovf); end
  endtask

  initial begin
    test_reset();
    test_ignored_idle();
    test_load();
    test_cool();
    test_run();
    test_dump();
    test_start_in_done();
    test_reset_mid_dump();
    test_overflow();
    $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
    $finish;
  end

endmodule
